// File: rtl/btn_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// btn_cmd_sequencer
//
// Purpose:
//   Converts three debounced push-button levels (mode, add, sub) into
//   one-cycle command pulses for the watch interface.
//   - Simultaneous presses resolve to a single owner (mode > add > sub).
//   - add/sub auto-repeat while held, so time fields can be stepped quickly.
//   - Buttons held through reset never produce a command.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  When defined, add/sub presses enter HOLD/REPEAT and
//                       auto-repeat. When undefined, add/sub behave like mode
//                       (single pulse, then wait for release). In that case
//                       the counter is not built and repeat_active is tied 0.
//
// Parameters:
//   HOLD_COUNT    cycles from the first add/sub pulse to the first repeat
//                 pulse (>= 2)
//   REPEAT_COUNT  cycles between consecutive repeat pulses (>= 2)
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   mode_button    debounced mode level
//   add_button     debounced add level
//   sub_button     debounced sub level
//   mode_pulse     one-cycle mode command (registered)
//   add_pulse      one-cycle add command (registered)
//   sub_pulse      one-cycle sub command (registered)
//   repeat_active  high while the FSM is auto-repeating (registered)
// -----------------------------------------------------------------------------
module btn_cmd_sequencer #(
  parameter int HOLD_COUNT   = 50000000,
  parameter int REPEAT_COUNT = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic mode_button,
  input  logic add_button,
  input  logic sub_button,
  output logic mode_pulse,
  output logic add_pulse,
  output logic sub_pulse,
  output logic repeat_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    REPEAT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  logic   any_button;

  assign any_button = mode_button | add_button | sub_button;

  // Out-of-range timing parameters leave this marker block in the hierarchy;
  // the counter logic assumes both counts are at least 2.
  if ((HOLD_COUNT < 2) || (REPEAT_COUNT < 2)) begin : g_count_range_violation
  end

`ifdef BTN_AUTO_REPEAT_EN

  typedef enum logic [1:0] {
    OWN_MODE = 2'd0,
    OWN_ADD  = 2'd1,
    OWN_SUB  = 2'd2
  } owner_t;

  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_COUNT - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_COUNT - 1);

  owner_t      owner;
  logic [31:0] cnt;
  logic        owner_level;

  // Level of whichever button currently owns the sequencer; the other
  // buttons are deliberately not looked at while an owner is active.
  always_comb begin
    owner_level = 1'b0;
    case (owner)
      OWN_MODE: owner_level = mode_button;
      OWN_ADD:  owner_level = add_button;
      OWN_SUB:  owner_level = sub_button;
      default:  owner_level = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // RELEASE (not IDLE) so a button held through reset is not a press.
      state         <= RELEASE;
      owner         <= OWN_MODE;
      cnt           <= '0;
      mode_pulse    <= 1'b0;
      add_pulse     <= 1'b0;
      sub_pulse     <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      mode_pulse <= 1'b0;
      add_pulse  <= 1'b0;
      sub_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          if (mode_button) begin
            owner      <= OWN_MODE;
            mode_pulse <= 1'b1;
            state      <= RELEASE;
          end else if (add_button) begin
            owner     <= OWN_ADD;
            add_pulse <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end else if (sub_button) begin
            owner     <= OWN_SUB;
            sub_pulse <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (!owner_level) begin
            state <= RELEASE;
          end else if (cnt == HOLD_LAST) begin
            // Only add/sub reach HOLD, so owner selects between those two.
            add_pulse     <= (owner == OWN_ADD);
            sub_pulse     <= (owner == OWN_SUB);
            repeat_active <= 1'b1;
            cnt           <= '0;
            state         <= REPEAT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        REPEAT: begin
          if (!owner_level) begin
            repeat_active <= 1'b0;
            state         <= RELEASE;
          end else if (cnt == REPEAT_LAST) begin
            add_pulse <= (owner == OWN_ADD);
            sub_pulse <= (owner == OWN_SUB);
            cnt       <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        RELEASE: begin
          // Wait for every button, not just the owner, before re-arming.
          if (!any_button) begin
            state <= IDLE;
          end
        end

        default: state <= RELEASE;
      endcase
    end
  end

`else

  // Without auto-repeat every press is a single pulse followed by RELEASE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RELEASE;
      mode_pulse    <= 1'b0;
      add_pulse     <= 1'b0;
      sub_pulse     <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      mode_pulse    <= 1'b0;
      add_pulse     <= 1'b0;
      sub_pulse     <= 1'b0;
      repeat_active <= 1'b0;

      case (state)
        IDLE: begin
          if (mode_button) begin
            mode_pulse <= 1'b1;
            state      <= RELEASE;
          end else if (add_button) begin
            add_pulse <= 1'b1;
            state     <= RELEASE;
          end else if (sub_button) begin
            sub_pulse <= 1'b1;
            state     <= RELEASE;
          end
        end

        RELEASE: begin
          if (!any_button) begin
            state <= IDLE;
          end
        end

        default: state <= RELEASE;
      endcase
    end
  end

`endif

endmodule
